// File: rtl/weight_row_loader.sv
// weight_row_loader: read-response end of the weight SRAM path.
// Forwards weight-controller reads to the SRAM, captures the returned rows
// into a shadow bank, and on a swap request copies the completed shadow
// bank into the active bank that drives the MAC array. This lets the next
// tile prefetch while the current tile computes.
module weight_row_loader #(
  parameter int MAC_ROW      = 16,
  parameter int MAC_COL      = 16,
  parameter int W_BITWIDTH   = 8,
  parameter int W_ADDR_BIT   = 11,
  parameter int SRAM_LATENCY = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    w_prefetch_in,
  input  logic                                    w_read_en_in,
  input  logic [W_ADDR_BIT-1:0]                   w_addr_in,
  output logic                                    sram_cs_out,
  output logic [W_ADDR_BIT-1:0]                   sram_addr_out,
  input  logic [MAC_COL*W_BITWIDTH-1:0]           sram_rdata_in,
  input  logic                                    swap_in,
  output logic                                    shadow_full_out,
  output logic [MAC_ROW*MAC_COL*W_BITWIDTH-1:0]   weight_out,
  output logic                                    weight_valid_out,
  output logic                                    overflow_err_out,
  output logic                                    swap_err_out
);

  localparam int ROW_W = MAC_COL * W_BITWIDTH;
  localparam int CNT_W = $clog2(MAC_ROW + 1);
  localparam int IDX_W = (MAC_ROW > 1) ? $clog2(MAC_ROW) : 1;
  localparam logic [CNT_W-1:0] ROWS_C = CNT_W'(MAC_ROW);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAC_ROW - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FULL
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_cap_cnt;
  logic [CNT_W-1:0] w_issue_base;
  logic             w_enter_fill;
  logic             w_swap_ok;
  logic             w_accept;
  logic             w_drop;

  // Tag pipeline: one stage per cycle of SRAM latency; the tail lines up
  // with the cycle in which the SRAM presents the matching row.
  logic [SRAM_LATENCY-1:0] r_pipe_vld;
  logic [IDX_W-1:0]        r_pipe_row [SRAM_LATENCY];
  logic                    w_tail_vld;
  logic [IDX_W-1:0]        w_tail_row;

  logic [MAC_ROW-1:0][ROW_W-1:0] r_shadow;
  logic [MAC_ROW-1:0][ROW_W-1:0] r_active;

  logic r_overflow;
  logic r_swap_err;
  logic r_weight_valid;

  assign w_tail_vld = r_pipe_vld[SRAM_LATENCY-1];
  assign w_tail_row = r_pipe_row[SRAM_LATENCY-1];

  // Next-state decode plus read acceptance; a fill can open from IDLE or
  // directly out of FULL when a prefetch coincides with the swap.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_enter_fill = 1'b0;
    w_swap_ok    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_prefetch_in) begin
          w_next_state = ST_FILL;
          w_enter_fill = 1'b1;
        end
      end
      ST_FILL: begin
        if (w_tail_vld && (r_cap_cnt == LAST_C)) begin
          w_next_state = ST_FULL;
        end
      end
      ST_FULL: begin
        if (swap_in) begin
          w_swap_ok = 1'b1;
          if (w_prefetch_in) begin
            w_next_state = ST_FILL;
            w_enter_fill = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    // A read in the cycle that opens a fill is row 0 of the new tile.
    w_issue_base = w_enter_fill ? '0 : r_issue_cnt;
    w_accept     = w_read_en_in && ((r_state == ST_FILL) || w_enter_fill) &&
                   (w_issue_base < ROWS_C);
    w_drop       = w_read_en_in && !w_accept;
  end

  // State register.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Issue/capture pointers and the valid half of the tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_pipe_vld  <= '0;
    end else begin
      if (w_accept) begin
        r_issue_cnt <= w_issue_base + 1'b1;
      end else if (w_enter_fill) begin
        r_issue_cnt <= '0;
      end
      if (w_enter_fill) begin
        r_cap_cnt <= '0;
      end else if (w_tail_vld) begin
        r_cap_cnt <= r_cap_cnt + 1'b1;
      end
      r_pipe_vld[0] <= w_accept;
      for (int i = 1; i < SRAM_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
    end
  end

  // Row-tag half of the pipeline.
  // NOTE: the row tags carry no reset; they are only consumed when the
  // matching valid bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    r_pipe_row[0] <= w_issue_base[IDX_W-1:0];
    for (int i = 1; i < SRAM_LATENCY; i++) begin
      r_pipe_row[i] <= r_pipe_row[i-1];
    end
  end

  // Shadow capture and shadow-to-active transfer. A capture and an accepted
  // swap never coincide: FULL is only reached once every return has landed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (w_tail_vld) begin
        r_shadow[w_tail_row] <= sram_rdata_in;
      end
      if (w_swap_ok) begin
        r_active <= r_shadow;
      end
    end
  end

  // Sticky status flags, each registered so they show one cycle after cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow     <= 1'b0;
      r_swap_err     <= 1'b0;
      r_weight_valid <= 1'b0;
    end else begin
      r_overflow     <= r_overflow | w_drop;
      r_swap_err     <= r_swap_err | (swap_in && (r_state != ST_FULL));
      r_weight_valid <= r_weight_valid | w_swap_ok;
    end
  end

  assign sram_cs_out      = w_accept;
  assign sram_addr_out    = w_addr_in;
  assign shadow_full_out  = (r_state == ST_FULL);
  assign weight_out       = r_active;
  assign weight_valid_out = r_weight_valid;
  assign overflow_err_out = r_overflow;
  assign swap_err_out     = r_swap_err;

endmodule
